// File: rtl/led_output_pio.sv
// LED output PIO: Avalon-MM slave with data, blink mask, atomic set/clear.
// Ports: clk, reset, address, chipselect, write_n, writedata, readdata, out_port.
module led_output_pio #(
  parameter int DATA_WIDTH  = 10,
  parameter int RESET_VALUE = 0,
  parameter int BLINK_DIV   = 25000000,
  parameter int DIV_WIDTH   = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [DATA_WIDTH-1:0] RST_DATA =
    DATA_WIDTH'(RESET_VALUE);
  localparam logic [DIV_WIDTH-1:0] DIV_LAST =
    DIV_WIDTH'(BLINK_DIV - 1);

  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] blink_mask;
  logic [DIV_WIDTH-1:0]  blink_cnt;
  logic                  blink_phase;

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic [DATA_WIDTH-1:0] gate;

  assign wr   = chipselect & ~write_n;
  assign wd   = writedata[DATA_WIDTH-1:0];
  assign gate = blink_mask & {DATA_WIDTH{blink_phase}};

  always_comb begin
    rd_mux = '0;
    unique case (address)
      2'd0: rd_mux = data_reg;
      2'd1: rd_mux = blink_mask;
      2'd2: rd_mux = out_port;
      2'd3: rd_mux = {{(DATA_WIDTH-1){1'b0}}, blink_phase};
      default: rd_mux = '0;
    endcase
  end

  // Set/clear are folded into one read-modify-write of data_reg.
  always_comb begin
    data_nxt = data_reg;
    if (wr) begin
      unique case (address)
        2'd0: data_nxt = wd;
        2'd2: data_nxt = data_reg | wd;
        2'd3: data_nxt = data_reg & ~wd;
        default: data_nxt = data_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg    <= RST_DATA;
      blink_mask  <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      readdata    <= '0;
      out_port    <= '0;
    end else begin
      readdata <= 32'(rd_mux);
      out_port <= data_reg & ~gate;
      data_reg <= data_nxt;
      if (wr && address == 2'd1) begin
        // New mask restarts blinking in the lit phase.
        blink_mask  <= wd;
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (blink_cnt == DIV_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_output_pio.sv
// Directed bench for led_output_pio.
// Hand-computed expectations, single check task.
module tb_led_output_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  out_port;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_output_pio #(
    .DATA_WIDTH (10),
    .RESET_VALUE(32'h155),
    .BLINK_DIV  (4),
    .DIV_WIDTH  (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  logic [31:0] r;
  logic        ph;

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // reset
    tick();
    tick();
    check("rst_rd", readdata, 32'h0);
    check("rst_out", {22'd0, out_port}, 32'h0);
    reset = 1'b0;
    tick();
    check("rel_out", {22'd0, out_port}, 32'h155);
    check("rel_rd0", readdata, 32'h155);

    // data write, upper bits dropped
    wr(2'd0, 32'hFFFFF2A5);
    check("wr_same_rd", readdata, 32'h155);
    check("wr_out_lag", {22'd0, out_port}, 32'h155);
    tick();
    check("wr_out", {22'd0, out_port}, 32'h2A5);
    rd(2'd0, r);
    check("wr_rd0", r, 32'h2A5);

    // set/clear back to back
    wr(2'd0, 32'h0);
    address    = 2'd2;
    writedata  = 32'h3;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    address   = 2'd3;
    writedata = 32'h1;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    rd(2'd0, r);
    check("setclr_rd0", r, 32'h2);
    rd(2'd2, r);
    check("setclr_rd2", r, 32'h2);
    wr(2'd2, 32'h0);
    wr(2'd3, 32'h0);
    rd(2'd0, r);
    check("zero_setclr", r, 32'h2);

    // blink engine
    wr(2'd0, 32'h201);
    wr(2'd1, 32'h001);
    address = 2'd3;
    for (int i = 1; i <= 16; i++) begin
      tick();
      ph = (((i - 1) / 4) % 2) == 1;
      check($sformatf("blk_out%0d", i),
            {22'd0, out_port},
            ph ? 32'h200 : 32'h201);
      check($sformatf("blk_ph%0d", i),
            readdata, {31'd0, ph});
    end

    // mid-blink rewrite of mask
    for (int i = 0; i < 4; i++) tick();
    wr(2'd1, 32'h001);
    check("mid_out_dark", {22'd0, out_port}, 32'h200);
    address = 2'd3;
    tick();
    check("mid_out_lit", {22'd0, out_port}, 32'h201);
    check("mid_ph0", readdata, 32'h0);
    rd(2'd0, r);
    check("mid_rd0", r, 32'h201);

    // mid-blink reset
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    check("mrst_out", {22'd0, out_port}, 32'h0);
    check("mrst_rd", readdata, 32'h0);
    reset = 1'b0;
    tick();
    check("mrst_out2", {22'd0, out_port}, 32'h155);
    rd(2'd1, r);
    check("mrst_mask", r, 32'h0);
    rd(2'd3, r);
    check("mrst_ph", r, 32'h0);

    // non-writes
    wr(2'd0, 32'h0AA);
    address    = 2'd0;
    writedata  = 32'h3FF;
    chipselect = 1'b0;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    address = 2'd1;
    tick();
    chipselect = 1'b0;
    rd(2'd0, r);
    check("nowr_rd0", r, 32'h0AA);
    rd(2'd1, r);
    check("nowr_rd1", r, 32'h0);

    // write during reset
    reset = 1'b1;
    wr(2'd0, 32'h3FF);
    reset = 1'b0;
    rd(2'd0, r);
    check("rst_wins", r, 32'h155);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
